// File: rtl/masked_and_seq_pkg.sv
// -----------------------------------------------------------------------------
// masked_and_seq_pkg
// Shared definitions for the masked AND gadget sequencer:
//   - state_e   : sequencer FSM states
//   - LFSR_W    : width of the internal mask LFSR
//   - LFSR_TAPS : feedback taps for x^64 + x^63 + x^61 + x^60 + 1
// -----------------------------------------------------------------------------
package masked_and_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int LFSR_W = 64;

  // Polynomial exponents 64, 63, 61, 60 map onto state bits 63, 62, 60, 59.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/masked_and_seq_lfsr64.sv
// -----------------------------------------------------------------------------
// masked_and_lfsr64
// Free-running 64-bit Fibonacci LFSR used as the mask source for the masked
// AND sequencer. Shifts every cycle; reloads SEED on reset.
//
// Parameters:
//   SEED   reset value (must be nonzero)
//   OUT_W  number of low state bits exposed on o_state (1..64)
// Ports:
//   i_clk    in   clock
//   i_rst    in   asynchronous active-high reset
//   o_state  out  OUT_W  low bits of the current LFSR state
// -----------------------------------------------------------------------------
module masked_and_lfsr64
  import masked_and_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 64'h0123_4567_89AB_CDEF,
  parameter int                OUT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [OUT_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic              w_feedback;

  assign w_feedback = ^(r_state & LFSR_TAPS);

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // reset in the sensitivity list, so every register in the block updates
  // from pre-edge values and reset takes effect without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
    end else begin
      r_state <= {r_state[LFSR_W-2:0], w_feedback};
    end
  end

  assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/masked_and_seq.sv
// -----------------------------------------------------------------------------
// masked_and_seq
// Sequencer for a first-order two-share masked AND gadget. Accepts shared
// operands, draws fresh masks, drives the gadget through its latch (LOAD) and
// evaluate (EVAL) phases, captures the result shares and returns them.
//
// Optional feature (macro MASKED_AND_SEQ_EXT_RAND_EN):
//   defined   - masks come from an external randomness handshake
//               (rnd_valid / rnd_ready / rnd_data); no internal LFSR.
//   undefined - masks come from the internal 64-bit LFSR (LFSR_SEED).
//
// Parameters:
//   WIDTH      share / mask width, 1..32 (2*WIDTH must fit in the LFSR)
//   LFSR_SEED  nonzero reset value of the mask LFSR
// Ports:
//   g_clk, g_rst         clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; ax^bx = x, ay^by = y
//   out_valid/out_ready  result handshake; qx^qy = x & y
//   g_ax..g_by           gadget operand drive
//   g_z0, g_z1           gadget masks
//   g_clk_en             gadget register enable (high only in LOAD)
//   g_qx, g_qy           gadget result shares
//   rnd_valid/rnd_ready/rnd_data  external masks (optional feature only)
// -----------------------------------------------------------------------------
module masked_and_seq
  import masked_and_seq_pkg::*;
#(
  parameter int                WIDTH     = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic               g_clk,
  input  logic               g_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ax,
  input  logic [WIDTH-1:0]   bx,
  input  logic [WIDTH-1:0]   ay,
  input  logic [WIDTH-1:0]   by,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   qx,
  output logic [WIDTH-1:0]   qy,
  output logic [WIDTH-1:0]   g_ax,
  output logic [WIDTH-1:0]   g_ay,
  output logic [WIDTH-1:0]   g_bx,
  output logic [WIDTH-1:0]   g_by,
  output logic [WIDTH-1:0]   g_z0,
  output logic [WIDTH-1:0]   g_z1,
  output logic               g_clk_en,
  input  logic [WIDTH-1:0]   g_qx,
  input  logic [WIDTH-1:0]   g_qy
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
  ,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [2*WIDTH-1:0] rnd_data
`endif
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_g_ax, r_g_ay, r_g_bx, r_g_by;
  logic [WIDTH-1:0]   r_g_z0, r_g_z1;
  logic               r_g_clk_en;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_qx, r_qy;

  logic               w_idle;
  logic               w_in_ready;
  logic               w_accept;
  logic [2*WIDTH-1:0] w_rand;

  // NOTE: in_ready is combinational from state, so it is also gated with the
  // reset input; otherwise it would read 1 while reset holds the FSM in IDLE.
  assign w_idle = (r_state == IDLE) && !g_rst;

`ifdef MASKED_AND_SEQ_EXT_RAND_EN
  // Operand and randomness handshakes complete together: each side is only
  // ready when the other side is offering.
  assign w_in_ready = w_idle && rnd_valid;
  assign rnd_ready  = w_idle && in_valid;
  assign w_rand     = rnd_data;
`else
  assign w_in_ready = w_idle;

  masked_and_lfsr64 #(
    .SEED  (LFSR_SEED),
    .OUT_W (2*WIDTH)
  ) u_lfsr (
    .i_clk   (g_clk),
    .i_rst   (g_rst),
    .o_state (w_rand)
  );
`endif

  assign w_accept = in_valid && w_in_ready;

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      r_state     <= IDLE;
      r_g_ax      <= '0;
      r_g_ay      <= '0;
      r_g_bx      <= '0;
      r_g_by      <= '0;
      r_g_z0      <= '0;
      r_g_z1      <= '0;
      r_g_clk_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_qx        <= '0;
      r_qy        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Operands and masks are frozen here and stay put until the
            // DONE->IDLE clear, covering both gadget phases.
            r_g_ax     <= ax;
            r_g_ay     <= ay;
            r_g_bx     <= bx;
            r_g_by     <= by;
            r_g_z0     <= w_rand[WIDTH-1:0];
            r_g_z1     <= w_rand[2*WIDTH-1:WIDTH];
            r_g_clk_en <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          // The gadget samples at the end of this cycle.
          r_g_clk_en <= 1'b0;
          r_state    <= EVAL;
        end
        EVAL: begin
          r_qx        <= g_qx;
          r_qy        <= g_qy;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            // Zero every share the gadget sees so the next operand set never
            // directly follows this one on the same wires.
            r_g_ax      <= '0;
            r_g_ay      <= '0;
            r_g_bx      <= '0;
            r_g_by      <= '0;
            r_g_z0      <= '0;
            r_g_z1      <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign qx        = r_qx;
  assign qy        = r_qy;
  assign g_ax      = r_g_ax;
  assign g_ay      = r_g_ay;
  assign g_bx      = r_g_bx;
  assign g_by      = r_g_by;
  assign g_z0      = r_g_z0;
  assign g_z1      = r_g_z1;
  assign g_clk_en  = r_g_clk_en;

endmodule

// File: tb/tb_masked_and_seq.sv
// -----------------------------------------------------------------------------
// tb_masked_and_seq
// Self-checking bench for masked_and_seq (WIDTH = 8). Contains a behavioural
// DOM-style masked AND gadget and a reference mask source. Builds with or
// without MASKED_AND_SEQ_EXT_RAND_EN.
// -----------------------------------------------------------------------------
module tb_masked_and_seq;

  localparam int          W    = 8;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic           g_clk = 1'b0;
  logic           g_rst;
  logic           in_valid, in_ready;
  logic [W-1:0]   ax, bx, ay, by;
  logic           out_valid, out_ready;
  logic [W-1:0]   qx, qy;
  logic [W-1:0]   g_ax, g_ay, g_bx, g_by, g_z0, g_z1;
  logic           g_clk_en;
  logic [W-1:0]   g_qx, g_qy;
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
  logic           rnd_valid, rnd_ready;
  logic [2*W-1:0] rnd_data;
`endif

  always #5 g_clk = ~g_clk;

  masked_and_seq #(.WIDTH(W), .LFSR_SEED(SEED)) dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ax        (ax),
    .bx        (bx),
    .ay        (ay),
    .by        (by),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .qx        (qx),
    .qy        (qy),
    .g_ax      (g_ax),
    .g_ay      (g_ay),
    .g_bx      (g_bx),
    .g_by      (g_by),
    .g_z0      (g_z0),
    .g_z1      (g_z1),
    .g_clk_en  (g_clk_en),
    .g_qx      (g_qx),
    .g_qy      (g_qy)
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    ,
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data)
`endif
  );

  // Behavioural gadget: registers its masked cross terms when enabled.
  // qx ^ qy = ax&ay ^ ax&by ^ bx&by ^ bx&ay = (ax^bx) & (ay^by).
  logic [W-1:0] gad_q0, gad_q1;
  always @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      gad_q0 <= '0;
      gad_q1 <= '0;
    end else if (g_clk_en) begin
      gad_q0 <= (g_ax & g_ay) ^ ((g_ax & g_by) ^ g_z0);
      gad_q1 <= (g_bx & g_by) ^ ((g_bx & g_ay) ^ g_z0);
    end
  end
  assign g_qx = gad_q0;
  assign g_qy = gad_q1;

  // Reference mask source: polynomial x^64 + x^63 + x^61 + x^60 + 1,
  // new bit = XOR of stages 64, 63, 61, 60, advancing every cycle.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], s[64-1] ^ s[63-1] ^ s[61-1] ^ s[60-1]};
  endfunction

  logic [63:0] m_lfsr;
  always @(posedge g_clk or posedge g_rst) begin
    if (g_rst) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
    n_vec++;
    if (act === bad) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected anything but 0x%0h", name, act, bad);
    end
  endtask

  function automatic logic [63:0] g_bus();
    return 64'({g_ax, g_ay, g_bx, g_by, g_z0, g_z1});
  endfunction

  // One complete operation, starting and ending at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a_x, input logic [W-1:0] b_x,
                        input logic [W-1:0] a_y, input logic [W-1:0] b_y,
                        input logic [2*W-1:0] rnd, input int rnd_delay, input int hold,
                        output logic [W-1:0] q0, output logic [W-1:0] q1,
                        output logic [W-1:0] z0_exp);
    logic [W-1:0]   x, y, z1_exp;
    logic [2*W-1:0] m;
    bit             ok;
    int             waits;
    x = a_x ^ b_x;
    y = a_y ^ b_y;
    q0 = '0; q1 = '0; z0_exp = '0;
    ax = a_x; bx = b_x; ay = a_y; by = b_y;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    rnd_valid = 1'b0;
    rnd_data  = rnd;
    for (int i = 0; i < rnd_delay; i++) begin
      #1;
      check("in_ready while rnd_valid low", 64'(in_ready), 64'(0));
      check("rnd_ready while in_valid high", 64'(rnd_ready), 64'(1));
      @(negedge g_clk);
      check("no gadget enable while stalled", 64'(g_clk_en), 64'(0));
    end
    rnd_valid = 1'b1;
`endif
    #1;
    ok = 1'b0;
    waits = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge g_clk); #1;
      waits++;
    end
    check("accept within budget", 64'(ok), 64'(1));
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    check("accept immediately when idle", 64'(waits), 64'(0));
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    m = rnd;
`else
    m = m_lfsr[2*W-1:0];
`endif
    z0_exp = m[W-1:0];
    z1_exp = m[2*W-1:W];
    // LOAD
    @(negedge g_clk);
    in_valid = 1'b0;
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    rnd_valid = 1'b0;
`endif
    check("LOAD g_clk_en", 64'(g_clk_en), 64'(1));
    check("LOAD g_z0", 64'(g_z0), 64'(z0_exp));
    check("LOAD g_z1", 64'(g_z1), 64'(z1_exp));
    check("LOAD operands", 64'({g_ax, g_bx, g_ay, g_by}), 64'({a_x, b_x, a_y, b_y}));
    check("LOAD in_ready", 64'(in_ready), 64'(0));
    check("LOAD out_valid", 64'(out_valid), 64'(0));
    // EVAL
    @(negedge g_clk);
    check("EVAL g_clk_en", 64'(g_clk_en), 64'(0));
    check("EVAL g_z0 stable", 64'(g_z0), 64'(z0_exp));
    check("EVAL g_z1 stable", 64'(g_z1), 64'(z1_exp));
    check("EVAL operands stable", 64'({g_ax, g_bx, g_ay, g_by}), 64'({a_x, b_x, a_y, b_y}));
    check("EVAL out_valid", 64'(out_valid), 64'(0));
    // DONE: 2 edges after the accept edge
    @(negedge g_clk);
    check("out_valid 2 edges after accept", 64'(out_valid), 64'(1));
    check("result qx^qy == x&y", 64'(qx ^ qy), 64'(x & y));
    check("DONE g_clk_en", 64'(g_clk_en), 64'(0));
    check("masks held to capture", 64'({g_z1, g_z0}), 64'({z1_exp, z0_exp}));
    q0 = qx;
    q1 = qy;
    for (int i = 0; i < hold; i++) begin
      @(negedge g_clk);
      check("hold qx/qy stable", 64'({qx, qy}), 64'({q0, q1}));
      check("hold out_valid", 64'(out_valid), 64'(1));
      check("hold in_ready", 64'(in_ready), 64'(0));
      check("hold g_clk_en", 64'(g_clk_en), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge g_clk);
    check("release out_valid low", 64'(out_valid), 64'(0));
    check("release qx/qy cleared", 64'({qx, qy}), 64'(0));
    check("release g_* cleared", g_bus(), 64'(0));
    check("release g_clk_en", 64'(g_clk_en), 64'(0));
`ifndef MASKED_AND_SEQ_EXT_RAND_EN
    #1;
    check("release back to IDLE", 64'(in_ready), 64'(1));
`endif
  endtask

  typedef struct {
    logic [W-1:0] ax, bx, ay, by;
    logic [W-1:0] q;
  } vec_t;

  initial begin
    vec_t           tbl[7];
    logic [W-1:0]   q0, q1, z0e;
    logic [2*W-1:0] rw;

    // {ax, bx, ay, by, expected x&y}
    tbl[0] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    tbl[1] = '{8'h5A, 8'hFF, 8'h11, 8'h2D, 8'h24};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    tbl[4] = '{8'hFF, 8'hFF, 8'hAB, 8'hCD, 8'h00};
    tbl[5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h26};
    tbl[6] = '{8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'hFF};

    g_rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    ax = '0; bx = '0; ay = '0; by = '0;
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    rnd_valid = 1'b0; rnd_data = '0;
`endif
    @(negedge g_clk);
    @(negedge g_clk);
    check("reset in_ready", 64'(in_ready), 64'(0));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset qx/qy", 64'({qx, qy}), 64'(0));
    check("reset g_*", g_bus(), 64'(0));
    check("reset g_clk_en", 64'(g_clk_en), 64'(0));
    g_rst = 1'b0;
    @(negedge g_clk);

`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    // No accept until randomness arrives; masks taken from rnd_data halves.
    run_op(8'h01, 8'h00, 8'h00, 8'h01, 16'hC35A, 5, 0, q0, q1, z0e);
    check("ext mask z0 from rnd_data low half", 64'(z0e), 64'h5A);
`endif

    // Table vectors, back to back with out_ready high.
    for (int i = 0; i < 7; i++) begin
      rw = 16'($urandom);
      run_op(tbl[i].ax, tbl[i].bx, tbl[i].ay, tbl[i].by, rw, 0, 0, q0, q1, z0e);
      check($sformatf("table vector %0d", i), 64'(q0 ^ q1), 64'(tbl[i].q));
      if (i == 1 && z0e != 8'h3C)
        check_ne("masked share qx differs from x&y", 64'(q0), 64'h24);
    end

    // Result held for 10 cycles of back-pressure.
    run_op(8'hA5, 8'h00, 8'h3C, 8'h00, 16'h7E81, 0, 10, q0, q1, z0e);
    check("held result", 64'(q0 ^ q1), 64'h24);

    // Reset pulsed during EVAL aborts the operation.
    ax = 8'h0F; bx = 8'h00; ay = 8'hFF; by = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    rnd_valid = 1'b1; rnd_data = 16'h1234;
`endif
    #1;
    check("abort op accepted", 64'(in_ready), 64'(1));
    @(negedge g_clk);
    in_valid = 1'b0;
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
    rnd_valid = 1'b0;
`endif
    check("abort op in LOAD", 64'(g_clk_en), 64'(1));
    @(negedge g_clk);
    g_rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'(0));
    check("abort g_* cleared", g_bus(), 64'(0));
    check("abort g_clk_en", 64'(g_clk_en), 64'(0));
    check("abort in_ready during reset", 64'(in_ready), 64'(0));
    @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    check("aborted result discarded", 64'(out_valid), 64'(0));
    check("abort stays idle", 64'(g_clk_en), 64'(0));
    // Next operation: masks come from the reseeded reference source.
    run_op(8'h6C, 8'h93, 8'h55, 8'hAA, 16'hBEEF, 0, 0, q0, q1, z0e);
    check("post-abort result", 64'(q0 ^ q1), 64'hFF);

    // Randomised operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      int rd;
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) @(negedge g_clk);
`ifdef MASKED_AND_SEQ_EXT_RAND_EN
      rd = int'($urandom_range(0, 2));
`else
      rd = 0;
`endif
      rw = 16'($urandom);
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), rw, rd,
             int'($urandom_range(0, 2)), q0, q1, z0e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
